fir_tap_feeder: RTL

FIR_TAP_FEEDER -- requirements
Module: fir_tap_feeder

---
 rtl/fir_tap_feeder.sv | 112 +++++++++++
 1 files changed

// File: rtl/fir_tap_feeder.sv
// Symmetric FIR pair feeder: one accepted sample yields PAIRS registered (x[i], x[TAPS-1-i], c[i]) beats, first beat one cycle after the accepting edge.
// s_ready is low for the whole pair sequence; a held s_valid is taken on the first edge back in IDLE.
module fir_tap_feeder #(
    parameter int DATA_BITS = 16,
    parameter int COEF_BITS = 16,
    parameter int TAPS      = 15,
    localparam int PAIRS    = (TAPS + 1) / 2,
    localparam int AW       = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 s_ready,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic [COEF_BITS-1:0] coef_wdata,
    output logic                 busy,
    output logic                 en,
    output logic [DATA_BITS-1:0] data_a,
    output logic [DATA_BITS-1:0] data_b,
    output logic [COEF_BITS-1:0] coef,
    output logic                 first,
    output logic                 last
);

    localparam int            XW       = $clog2(TAPS);
    localparam bit            ODD      = (TAPS % 2) == 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(PAIRS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [AW-1:0]        idx;
    logic [XW-1:0]        a_idx;
    logic [XW-1:0]        b_idx;
    logic                 idx_last;
    logic                 accept;
    logic [DATA_BITS-1:0] x [TAPS];
    logic [COEF_BITS-1:0] c [PAIRS];

    assign a_idx    = XW'(idx);
    assign b_idx    = XW'(TAPS - 1) - XW'(idx);
    assign idx_last = (idx == LAST_IDX);
    assign accept   = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid) state_nxt = RUN;
            RUN:     if (idx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == IDLE);
        busy    = (state != IDLE);
    end

    // Out-of-range pair indices are dropped rather than aliased onto a real entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PAIRS; k++) c[k] <= '0;
        end else if (coef_we && ({1'b0, coef_addr} < (AW + 1)'(PAIRS))) begin
            c[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) x[k] <= '0;
            idx    <= '0;
            en     <= 1'b0;
            first  <= 1'b0;
            last   <= 1'b0;
            data_a <= '0;
            data_b <= '0;
            coef   <= '0;
        end else begin
            en    <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
                    x[0] <= s_data;
                    idx  <= '0;
                end
            end else begin
                en     <= 1'b1;
                first  <= (idx == '0);
                last   <= idx_last;
                data_a <= x[a_idx];
                // Centre tap of an odd filter appears once, so its mirror is zeroed.
                data_b <= (ODD && idx_last) ? '0 : x[b_idx];
                coef   <= c[idx];
                idx    <= idx_last ? '0 : idx + 1'b1;
            end
        end
    end

endmodule
